// File: rtl/ecpri_sdp_ram_if.sv
// Port bundle for ecpri_sdp_ram: byte-enabled write port, read request/response
// handshake and the post-reset zero-fill status.
interface ecpri_sdp_ram_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32
);
  logic                      init_busy;
  logic                      wr_en;
  logic [ADDR_WIDTH-1:0]     wr_addr;
  logic [DATA_WIDTH-1:0]     wr_data;
  logic [DATA_WIDTH/8-1:0]   wr_be;
  logic                      wr_err;
  logic                      rd_req;
  logic [ADDR_WIDTH-1:0]     rd_addr;
  logic                      rd_req_ready;
  logic                      rd_valid;
  logic                      rd_accept;
  logic [DATA_WIDTH-1:0]     rd_data;
  logic                      rd_err;

  modport slave (
    output init_busy, wr_err, rd_req_ready, rd_valid, rd_data, rd_err,
    input  wr_en, wr_addr, wr_data, wr_be, rd_req, rd_addr, rd_accept
  );

  modport master (
    input  init_busy, wr_err, rd_req_ready, rd_valid, rd_data, rd_err,
    output wr_en, wr_addr, wr_data, wr_be, rd_req, rd_addr, rd_accept
  );
endinterface

// File: rtl/ecpri_sdp_ram.sv
// Simple-dual-port payload RAM: byte-enabled write port, handshaked read port with
// 1- or 2-cycle latency, selectable read-during-write policy and optional zero-fill.
//
// state  | meaning
// S_INIT | zero-fill sweep, one word per cycle; reads and user writes blocked
// S_RUN  | normal operation
module ecpri_sdp_ram #(
  parameter int ADDR_WIDTH    = 16,
  parameter int DATA_WIDTH    = 32,
  parameter int DEPTH         = 256,
  parameter int READ_LATENCY  = 1,
  parameter int RDW_MODE      = 0,
  parameter int INIT_ON_RESET = 1
) (
  input  logic           clk,
  input  logic           rst,
  ecpri_sdp_ram_if.slave bus
);

  localparam int                  BE_W     = DATA_WIDTH / 8;
  localparam int                  IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_A  = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [IDX_W-1:0]    LAST_IDX = IDX_W'(DEPTH - 1);

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t                state_q, state_d;
  logic [IDX_W-1:0]      cnt_q, cnt_d;
  logic                  init_we;
  logic                  run;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  wr_ok, rd_ok;
  logic [IDX_W-1:0]      wr_idx, rd_idx;
  logic                  user_we;
  logic [DATA_WIDTH-1:0] wr_merged;
  logic [DATA_WIDTH-1:0] rd_word;

  logic                  stall;
  logic                  rd_ready;
  logic                  rd_acc;
  logic                  rd_valid_q;
  logic [DATA_WIDTH-1:0] rd_data_q;
  logic                  rd_err_q;
  logic                  wr_err_q;

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= (INIT_ON_RESET != 0) ? S_INIT : S_RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    init_we = 1'b0;
    run     = 1'b0;
    case (state_q)
      S_INIT: begin
        init_we = 1'b1;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST_IDX) begin
          state_d = S_RUN;
          cnt_d   = '0;
        end
      end
      S_RUN: begin
        run = 1'b1;
      end
      default: begin
        state_d = S_RUN;
      end
    endcase
  end

  assign bus.init_busy = (state_q == S_INIT);

  assign wr_ok   = ({1'b0, bus.wr_addr} < DEPTH_A);
  assign rd_ok   = ({1'b0, bus.rd_addr} < DEPTH_A);
  assign wr_idx  = bus.wr_addr[IDX_W-1:0];
  assign rd_idx  = bus.rd_addr[IDX_W-1:0];
  assign user_we = run && !rst && bus.wr_en && wr_ok;

  always_comb begin
    wr_merged = mem[wr_idx];
    for (int b = 0; b < BE_W; b++) begin
      if (bus.wr_be[b]) wr_merged[8*b +: 8] = bus.wr_data[8*b +: 8];
    end
  end

  // The sweep owns the array while it runs; user writes only land in S_RUN.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (init_we) begin
        mem[cnt_q] <= '0;
      end else if (user_we) begin
        mem[wr_idx] <= wr_merged;
      end
    end
  end

  always_comb begin
    rd_word = mem[rd_idx];
    if ((RDW_MODE != 0) && user_we && (wr_idx == rd_idx)) rd_word = wr_merged;
    if (!rd_ok) rd_word = '0;
  end

  assign stall    = rd_valid_q && !bus.rd_accept;
  assign rd_ready = run && !rst && !stall;
  assign rd_acc   = bus.rd_req && rd_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_err_q <= 1'b0;
    end else begin
      wr_err_q <= run && bus.wr_en && !wr_ok;
    end
  end

  generate
    if (READ_LATENCY == 2) begin : g_rl2
      logic                  s1_valid;
      logic [DATA_WIDTH-1:0] s1_data;
      logic                  s1_err;

      // A stall freezes both stages, so the word parked in stage 1 survives it.
      always_ff @(posedge clk) begin
        if (rst) begin
          s1_valid   <= 1'b0;
          s1_data    <= '0;
          s1_err     <= 1'b0;
          rd_valid_q <= 1'b0;
          rd_data_q  <= '0;
          rd_err_q   <= 1'b0;
        end else if (!stall) begin
          s1_valid   <= rd_acc;
          if (rd_acc) begin
            s1_data <= rd_word;
            s1_err  <= !rd_ok;
          end
          rd_valid_q <= s1_valid;
          if (s1_valid) begin
            rd_data_q <= s1_data;
            rd_err_q  <= s1_err;
          end
        end
      end
    end else begin : g_rl1
      always_ff @(posedge clk) begin
        if (rst) begin
          rd_valid_q <= 1'b0;
          rd_data_q  <= '0;
          rd_err_q   <= 1'b0;
        end else if (!stall) begin
          rd_valid_q <= rd_acc;
          if (rd_acc) begin
            rd_data_q <= rd_word;
            rd_err_q  <= !rd_ok;
          end
        end
      end
    end
  endgenerate

  assign bus.rd_req_ready = rd_ready;
  assign bus.rd_valid     = rd_valid_q;
  assign bus.rd_data      = rd_data_q;
  assign bus.rd_err       = rd_err_q;
  assign bus.wr_err       = wr_err_q;

endmodule
